// File: rtl/logip_sump_pkg.sv
// Shared SUMP command definitions for the LogIP command controller.
package logip_sump_pkg;

  // Short (single-byte) commands: bit 7 clear
  localparam logic [7:0] OP_RESET     = 8'h00;
  localparam logic [7:0] OP_RUN       = 8'h01;
  localparam logic [7:0] OP_ID        = 8'h02;
  localparam logic [7:0] OP_META      = 8'h04;
  localparam logic [7:0] OP_XON       = 8'h11;
  localparam logic [7:0] OP_XOFF      = 8'h13;

  // Long commands: bit 7 set, followed by four argument bytes
  localparam logic [7:0] OP_DIV       = 8'h80;
  localparam logic [7:0] OP_CNT       = 8'h81;
  localparam logic [7:0] OP_FLAGS     = 8'h82;
  localparam logic [7:0] OP_TRG_MASK0 = 8'hC0;
  localparam logic [7:0] OP_TRG_VAL0  = 8'hC1;
  localparam logic [7:0] OP_TRG_CFG0  = 8'hC2;

  // Number of argument bytes that follow a long opcode
  localparam int unsigned ARG_BYTES = 4;

  typedef enum logic {
    IDLE = 1'b0,
    ARG  = 1'b1
  } sump_state_t;

endpackage

// File: rtl/sump_cmd_ctrl.sv
// SUMP command decoder: turns received UART bytes into control pulses
// and capture-configuration registers, with an inter-byte timeout that
// abandons long commands whose argument bytes stop arriving.
module sump_cmd_ctrl
  import logip_sump_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000,
  parameter int unsigned DIV_BITS       = 24,
  parameter int unsigned CNT_BITS       = 16
) (
  input  logic                clk_i,
  input  logic                rst_in,
  input  logic [7:0]          rx_data_i,
  input  logic                rx_rdy_i,
  input  logic                busy_i,
  output logic                soft_rst_o,
  output logic                arm_o,
  output logic                id_req_o,
  output logic                meta_req_o,
  output logic                xoff_o,
  output logic                cmd_err_o,
  output logic [31:0]         trg_mask_o,
  output logic [31:0]         trg_val_o,
  output logic [31:0]         trg_cfg_o,
  output logic [DIV_BITS-1:0] div_o,
  output logic [CNT_BITS-1:0] read_cnt_o,
  output logic [CNT_BITS-1:0] delay_cnt_o,
  output logic [7:0]          flags_o
);

  // The timeout counter only ever needs to hold TIMEOUT_CYCLES-1.
  localparam int unsigned     TMO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       CNT_LAST = 2'(ARG_BYTES - 1);

  sump_state_t         state_reg;
  logic [7:0]          opcode_reg;
  logic [1:0]          byte_cnt_reg;
  logic [31:0]         arg_reg;
  logic [TMO_W-1:0]    tmo_cnt_reg;

  logic                soft_rst_reg;
  logic                arm_reg;
  logic                id_req_reg;
  logic                meta_req_reg;
  logic                xoff_reg;
  logic                cmd_err_reg;
  logic [31:0]         trg_mask_reg;
  logic [31:0]         trg_val_reg;
  logic [31:0]         trg_cfg_reg;
  logic [DIV_BITS-1:0] div_reg;
  logic [CNT_BITS-1:0] read_cnt_reg;
  logic [CNT_BITS-1:0] delay_cnt_reg;
  logic [7:0]          flags_reg;

  // Argument as it will look once the current byte is shifted in; used so
  // the final byte's register write lands in the cycle right after its strobe.
  logic [31:0] arg_next;
  assign arg_next = {rx_data_i, arg_reg[31:8]};

  // Command FSM: decode, argument collection, timeout and register updates.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_reg     <= IDLE;
      opcode_reg    <= 8'h00;
      byte_cnt_reg  <= 2'd0;
      arg_reg       <= 32'h0;
      tmo_cnt_reg   <= '0;
      soft_rst_reg  <= 1'b0;
      arm_reg       <= 1'b0;
      id_req_reg    <= 1'b0;
      meta_req_reg  <= 1'b0;
      xoff_reg      <= 1'b0;
      cmd_err_reg   <= 1'b0;
      trg_mask_reg  <= 32'h0;
      trg_val_reg   <= 32'h0;
      trg_cfg_reg   <= 32'h0;
      div_reg       <= '0;
      read_cnt_reg  <= '0;
      delay_cnt_reg <= '0;
      flags_reg     <= 8'h00;
    end else begin
      // Pulses default low so each is exactly one cycle wide
      soft_rst_reg <= 1'b0;
      arm_reg      <= 1'b0;
      id_req_reg   <= 1'b0;
      meta_req_reg <= 1'b0;
      cmd_err_reg  <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (rx_rdy_i) begin
            if (rx_data_i[7]) begin
              opcode_reg   <= rx_data_i;
              byte_cnt_reg <= 2'd0;
              tmo_cnt_reg  <= '0;
              state_reg    <= ARG;
            end else begin
              case (rx_data_i)
                OP_RESET: begin
                  soft_rst_reg <= 1'b1;
                  xoff_reg     <= 1'b0;
                end
                OP_RUN: begin
                  // Arming an already-busy core is flagged rather than forwarded
                  if (busy_i) cmd_err_reg <= 1'b1;
                  else        arm_reg     <= 1'b1;
                end
                OP_ID:   id_req_reg   <= 1'b1;
                OP_META: meta_req_reg <= 1'b1;
                OP_XON:  xoff_reg     <= 1'b0;
                OP_XOFF: xoff_reg     <= 1'b1;
                default: ;
              endcase
            end
          end
        end

        ARG: begin
          if (rx_rdy_i) begin
            // A byte in the terminal-count cycle still counts as on time
            arg_reg      <= arg_next;
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            tmo_cnt_reg  <= '0;
            if (byte_cnt_reg == CNT_LAST) begin
              state_reg <= IDLE;
              case (opcode_reg)
                OP_TRG_MASK0: trg_mask_reg <= arg_next;
                OP_TRG_VAL0:  trg_val_reg  <= arg_next;
                OP_TRG_CFG0:  trg_cfg_reg  <= arg_next;
                OP_DIV:       div_reg      <= DIV_BITS'(arg_next);
                OP_CNT: begin
                  read_cnt_reg  <= CNT_BITS'(arg_next[15:0]);
                  delay_cnt_reg <= CNT_BITS'(arg_next[31:16]);
                end
                OP_FLAGS:     flags_reg    <= arg_next[7:0];
                default: ;
              endcase
            end
          end else if (tmo_cnt_reg == TMO_LAST) begin
            state_reg   <= IDLE;
            tmo_cnt_reg <= '0;
            cmd_err_reg <= 1'b1;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign soft_rst_o  = soft_rst_reg;
  assign arm_o       = arm_reg;
  assign id_req_o    = id_req_reg;
  assign meta_req_o  = meta_req_reg;
  assign xoff_o      = xoff_reg;
  assign cmd_err_o   = cmd_err_reg;
  assign trg_mask_o  = trg_mask_reg;
  assign trg_val_o   = trg_val_reg;
  assign trg_cfg_o   = trg_cfg_reg;
  assign div_o       = div_reg;
  assign read_cnt_o  = read_cnt_reg;
  assign delay_cnt_o = delay_cnt_reg;
  assign flags_o     = flags_reg;

endmodule

// File: tb/tb_sump_cmd_ctrl.sv
// Directed bench for sump_cmd_ctrl with an expected-output scoreboard.
module tb_sump_cmd_ctrl;

  localparam int unsigned TMO = 16;

  logic        clk_i = 1'b0;
  logic        rst_in;
  logic [7:0]  rx_data_i;
  logic        rx_rdy_i;
  logic        busy_i;
  logic        soft_rst_o, arm_o, id_req_o, meta_req_o, xoff_o, cmd_err_o;
  logic [31:0] trg_mask_o, trg_val_o, trg_cfg_o;
  logic [23:0] div_o;
  logic [15:0] read_cnt_o, delay_cnt_o;
  logic [7:0]  flags_o;

  sump_cmd_ctrl #(
    .TIMEOUT_CYCLES(TMO),
    .DIV_BITS      (24),
    .CNT_BITS      (16)
  ) dut (
    .clk_i      (clk_i),
    .rst_in     (rst_in),
    .rx_data_i  (rx_data_i),
    .rx_rdy_i   (rx_rdy_i),
    .busy_i     (busy_i),
    .soft_rst_o (soft_rst_o),
    .arm_o      (arm_o),
    .id_req_o   (id_req_o),
    .meta_req_o (meta_req_o),
    .xoff_o     (xoff_o),
    .cmd_err_o  (cmd_err_o),
    .trg_mask_o (trg_mask_o),
    .trg_val_o  (trg_val_o),
    .trg_cfg_o  (trg_cfg_o),
    .div_o      (div_o),
    .read_cnt_o (read_cnt_o),
    .delay_cnt_o(delay_cnt_o),
    .flags_o    (flags_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        soft_rst;
    logic        arm;
    logic        id_req;
    logic        meta_req;
    logic        cmd_err;
    logic        xoff;
    logic [31:0] mask;
    logic [31:0] val;
    logic [31:0] cfg;
    logic [23:0] div;
    logic [15:0] rd;
    logic [15:0] dly;
    logic [7:0]  flags;
  } outs_t;

  // Pulse selectors: {soft_rst, arm, id_req, meta_req, cmd_err}
  localparam logic [4:0] P_NONE = 5'b00000;
  localparam logic [4:0] P_SRST = 5'b10000;
  localparam logic [4:0] P_ARM  = 5'b01000;
  localparam logic [4:0] P_ID   = 5'b00100;
  localparam logic [4:0] P_META = 5'b00010;
  localparam logic [4:0] P_ERR  = 5'b00001;

  outs_t base = '0;   // expected level/register state
  outs_t sb[$];       // expected outputs, one entry per checked cycle
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic push_exp(input logic [4:0] p);
    outs_t e;
    e          = base;
    e.soft_rst = p[4];
    e.arm      = p[3];
    e.id_req   = p[2];
    e.meta_req = p[1];
    e.cmd_err  = p[0];
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    outs_t obs;
    outs_t exp;
    obs = {soft_rst_o, arm_o, id_req_o, meta_req_o, cmd_err_o, xoff_o,
           trg_mask_o, trg_val_o, trg_cfg_o, div_o, read_cnt_o, delay_cnt_o, flags_o};
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s: observed=%h required=<scoreboard entry>", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        n_err++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  // Strobe one byte (called at a negedge); outputs are checked one cycle later
  task automatic send(input logic [7:0] b, input logic [4:0] p, input string tag);
    rx_data_i = b;
    rx_rdy_i  = 1'b1;
    push_exp(p);
    @(negedge clk_i);
    rx_rdy_i  = 1'b0;
    $display("txn %s: byte=%02h pulses=%05b", tag, b, p);
    check_out(tag);
  endtask

  // One cycle with no strobe
  task automatic step(input logic [4:0] p, input string tag);
    push_exp(p);
    @(negedge clk_i);
    check_out(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(P_NONE, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_in    = 1'b0;
    rx_data_i = 8'h00;
    rx_rdy_i  = 1'b0;
    busy_i    = 1'b0;
    repeat (3) @(negedge clk_i);
    push_exp(P_NONE);
    check_out("reset_state");
    rst_in = 1'b1;
    @(negedge clk_i);

    // ID then metadata on consecutive strobes
    send(8'h02, P_ID,   "id");
    send(8'h04, P_META, "meta");
    idle(2, "pulse_width");

    // Unknown short opcode is ignored
    send(8'h05, P_NONE, "unk_short");

    // Divider
    send(8'h80, P_NONE, "div_op");
    send(8'h40, P_NONE, "div_a0");
    send(8'h42, P_NONE, "div_a1");
    send(8'h0F, P_NONE, "div_a2");
    base.div = 24'h0F4240;
    send(8'hAA, P_NONE, "div_a3");

    // Read / delay counts
    send(8'h81, P_NONE, "cnt_op");
    send(8'hFF, P_NONE, "cnt_a0");
    send(8'h03, P_NONE, "cnt_a1");
    send(8'h10, P_NONE, "cnt_a2");
    base.rd  = 16'h03FF;
    base.dly = 16'h0010;
    send(8'h00, P_NONE, "cnt_a3");

    // Trigger mask, kept for the timeout check below
    send(8'hC0, P_NONE, "mask_op");
    send(8'h11, P_NONE, "mask_a0");
    send(8'h22, P_NONE, "mask_a1");
    send(8'h33, P_NONE, "mask_a2");
    base.mask = 32'h44332211;
    send(8'h44, P_NONE, "mask_a3");

    // Trigger value: set nonzero, then all-zero argument bytes (not commands)
    send(8'hC1, P_NONE, "val_op");
    send(8'hEF, P_NONE, "val_a0");
    send(8'hBE, P_NONE, "val_a1");
    send(8'hAD, P_NONE, "val_a2");
    base.val = 32'hDEADBEEF;
    send(8'hDE, P_NONE, "val_a3");
    send(8'hC1, P_NONE, "val0_op");
    send(8'h00, P_NONE, "val0_a0");
    send(8'h00, P_NONE, "val0_a1");
    send(8'h00, P_NONE, "val0_a2");
    base.val = 32'h0;
    send(8'h00, P_NONE, "val0_a3");
    send(8'h01, P_ARM,  "arm_idle");

    // Unknown long opcode swallows its four bytes silently
    send(8'hFF, P_NONE, "unk_long_op");
    for (int i = 0; i < 4; i++) send(8'h01, P_NONE, "unk_long_arg");
    idle(1, "unk_long_after");

    // Timeout: TMO idle cycles after the last byte abort the command
    send(8'hC0, P_NONE, "tmo_op");
    send(8'h12, P_NONE, "tmo_a0");
    idle(TMO - 1, "tmo_wait");
    step(P_ERR, "tmo_err");
    idle(1, "tmo_after");
    send(8'h02, P_ID, "id_after_tmo");

    // A byte arriving on the terminal-count cycle is accepted
    send(8'hC2, P_NONE, "edge_op");
    send(8'h01, P_NONE, "edge_a0");
    idle(TMO - 1, "edge_wait0");
    send(8'h02, P_NONE, "edge_a1");
    idle(TMO - 1, "edge_wait1");
    send(8'h03, P_NONE, "edge_a2");
    idle(TMO - 1, "edge_wait2");
    base.cfg = 32'h04030201;
    send(8'h04, P_NONE, "edge_a3");
    idle(1, "edge_after");

    // Flow control and soft reset
    base.xoff = 1'b1;
    send(8'h13, P_NONE, "xoff_set");
    base.xoff = 1'b0;
    send(8'h11, P_NONE, "xon");
    base.xoff = 1'b1;
    send(8'h13, P_NONE, "xoff_set2");
    base.xoff = 1'b0;
    send(8'h00, P_SRST, "soft_rst");
    busy_i = 1'b1;
    send(8'h01, P_ERR, "arm_busy");
    busy_i = 1'b0;

    // Asynchronous reset in the middle of a long command
    base.xoff = 1'b1;
    send(8'h13, P_NONE, "xoff_pre_rst");
    send(8'h82, P_NONE, "flags_op_abort");
    send(8'h07, P_NONE, "flags_a0_abort");
    rst_in = 1'b0;
    #1;
    base = '0;
    push_exp(P_NONE);
    check_out("async_reset");
    @(negedge clk_i);
    step(P_NONE, "in_reset");
    rst_in = 1'b1;
    @(negedge clk_i);
    send(8'h82, P_NONE, "flags_op");
    send(8'h05, P_NONE, "flags_a0");
    send(8'h00, P_NONE, "flags_a1");
    send(8'h00, P_NONE, "flags_a2");
    base.flags = 8'h05;
    send(8'h00, P_NONE, "flags_a3");
    idle(2, "final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
